// File: rtl/fighter_pkg.sv
// Shared fighter definitions: movement state encodings,
// button bit indices and screen geometry.
package fighter_pkg;

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_WALK   = 3'd1,
    ST_CROUCH = 3'd2,
    ST_RISE   = 3'd3,
    ST_FALL   = 3'd4
  } move_t;

  localparam int IN_LEFT   = 0;
  localparam int IN_RIGHT  = 1;
  localparam int IN_JUMP   = 2;
  localparam int IN_CROUCH = 3;
  localparam int IN_PUNCH  = 4;
  localparam int IN_KICK   = 5;
  localparam int IN_SHIELD = 6;

  localparam int VIS_X0      = 144;
  localparam int VIS_X1      = 783;
  localparam int GROUND_LINE = 394;
  localparam int SPRITE_W    = 128;
  localparam int SPRITE_H    = 128;

  function automatic logic is_air(move_t s);
    return (s == ST_RISE) || (s == ST_FALL);
  endfunction

endpackage

// File: rtl/player_motion.sv
// Per-fighter movement engine: walk, crouch, gravity jump,
// screen and opponent blocking, stepped once per frame.
module player_motion
  import fighter_pkg::*;
#(
  parameter int START_X    = 200,
  parameter int GROUND_Y   = GROUND_LINE - SPRITE_H,
  parameter int MIN_X      = VIS_X0,
  parameter int MAX_X      = VIS_X1 - SPRITE_W + 1,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MIN_GAP    = 96
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       frame_tick,
  input  logic [6:0] player_inputs,
  input  logic [9:0] opp_x,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       facing_left,
  output logic       airborne,
  output logic [2:0] move_state
);

  localparam logic signed [11:0] L_WS  = 12'(WALK_SPEED);
  localparam logic signed [11:0] L_GAP = 12'(MIN_GAP);
  localparam logic signed [11:0] L_MIN = 12'(MIN_X);
  localparam logic signed [11:0] L_MAX = 12'(MAX_X);
  localparam logic signed [11:0] L_GND = 12'(GROUND_Y);
  localparam logic signed [5:0]  L_JV  = 6'(JUMP_VEL);
  localparam logic signed [5:0]  L_G   = 6'(GRAVITY);

  move_t             r_state, w_state_n;
  logic [9:0]        r_x, r_y, w_x_n, w_y_n, w_xmove;
  logic signed [5:0] r_vy, w_vy_n, w_vysum;
  logic              r_face, w_face_n;
  logic              r_air, r_jump_prev;
  logic              w_left, w_right, w_jump, w_crouch;
  logic              w_rise, w_go_l, w_go_r;
  logic signed [11:0] w_xcur, w_opp, w_xc, w_xs;
  logic signed [11:0] w_lim, w_xo, w_ysum;

  assign w_left   = player_inputs[IN_LEFT];
  assign w_right  = player_inputs[IN_RIGHT];
  assign w_jump   = player_inputs[IN_JUMP];
  assign w_crouch = player_inputs[IN_CROUCH];
  assign w_rise   = w_jump & ~r_jump_prev;
  assign w_go_r   = w_right & ~w_left;
  assign w_go_l   = w_left & ~w_right;

  // Horizontal step with screen clamp, then opponent clamp
  always_comb begin
    w_xcur = $signed({2'b00, r_x});
    w_opp  = $signed({2'b00, opp_x});
    w_lim  = '0;
    unique case (1'b1)
      w_go_r:  w_xc = w_xcur + L_WS;
      w_go_l:  w_xc = w_xcur - L_WS;
      default: w_xc = w_xcur;
    endcase
    if (w_xc < L_MIN)      w_xs = L_MIN;
    else if (w_xc > L_MAX) w_xs = L_MAX;
    else                   w_xs = w_xc;
    w_xo = w_xs;
    if (w_go_r && (w_opp > w_xcur)) begin
      w_lim = w_opp - L_GAP;
      if (w_xs > w_lim)
        w_xo = (w_lim > w_xcur) ? w_lim : w_xcur;
    end else if (w_go_l && (w_opp < w_xcur)) begin
      w_lim = w_opp + L_GAP;
      if (w_xs < w_lim)
        w_xo = (w_lim < w_xcur) ? w_lim : w_xcur;
    end
    w_xmove = w_xo[9:0];
  end

  // Next-state and vertical dynamics
  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_vy_n    = r_vy;
    w_ysum    = $signed({2'b00, r_y}) + 12'(r_vy);
    w_vysum   = r_vy + L_G;
    unique case (r_state)
      ST_STAND, ST_WALK, ST_CROUCH: begin
        if (w_rise) begin
          w_state_n = ST_RISE;
          w_vy_n    = -L_JV;
          w_x_n     = w_xmove;
        end else if (w_crouch) begin
          w_state_n = ST_CROUCH;
        end else if (w_go_r || w_go_l) begin
          w_state_n = ST_WALK;
          w_x_n     = w_xmove;
        end else begin
          w_state_n = ST_STAND;
        end
      end
      ST_RISE: begin
        w_x_n = w_xmove;
        if (w_ysum < 0) begin
          w_y_n     = '0;
          w_vy_n    = '0;
          w_state_n = ST_FALL;
        end else begin
          w_y_n  = w_ysum[9:0];
          w_vy_n = w_vysum;
          if (w_vysum >= 0) w_state_n = ST_FALL;
        end
      end
      ST_FALL: begin
        w_x_n = w_xmove;
        if (w_ysum >= L_GND) begin
          w_y_n     = L_GND[9:0];
          w_vy_n    = '0;
          w_state_n = ST_STAND;
        end else begin
          w_y_n  = w_ysum[9:0];
          w_vy_n = w_vysum;
        end
      end
      default: w_state_n = ST_STAND;
    endcase
    w_face_n = is_air(w_state_n) ? r_face : (opp_x < w_x_n);
  end

  // State register: reset wins, otherwise advance on frame tick only
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state     <= ST_STAND;
      r_x         <= 10'(START_X);
      r_y         <= 10'(GROUND_Y);
      r_vy        <= '0;
      r_face      <= 1'b0;
      r_air       <= 1'b0;
      r_jump_prev <= 1'b1;
    end else if (frame_tick) begin
      r_state     <= w_state_n;
      r_x         <= w_x_n;
      r_y         <= w_y_n;
      r_vy        <= w_vy_n;
      r_face      <= w_face_n;
      r_air       <= is_air(w_state_n);
      r_jump_prev <= w_jump;
    end
  end

  // Outputs straight from registers
  always_comb begin
    player_x    = r_x;
    player_y    = r_y;
    facing_left = r_face;
    airborne    = r_air;
    move_state  = r_state;
  end

endmodule

// File: tb/tb_player_motion.sv
// Directed self-checking bench for player_motion.
// Stimulus on negedge, results sampled on the following negedge.
module tb_player_motion;

  localparam logic [2:0] S_STAND  = 3'd0;
  localparam logic [2:0] S_WALK   = 3'd1;
  localparam logic [2:0] S_CROUCH = 3'd2;
  localparam logic [2:0] S_RISE   = 3'd3;
  localparam logic [2:0] S_FALL   = 3'd4;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       frame_tick = 1'b0;
  logic [6:0] player_inputs = '0;
  logic [9:0] opp_x = 10'd1000;
  logic [9:0] player_x, player_y;
  logic       facing_left, airborne;
  logic [2:0] move_state;

  int n_tests = 0;
  int n_fail  = 0;

  player_motion dut (
    .clk(clk), .rst_l(rst_l), .frame_tick(frame_tick),
    .player_inputs(player_inputs), .opp_x(opp_x),
    .player_x(player_x), .player_y(player_y),
    .facing_left(facing_left), .airborne(airborne),
    .move_state(move_state)
  );

  always #5 clk = ~clk;

  // inputs bits: [0]left [1]right [2]jump [3]crouch
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_l = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_l = 1'b1;
  endtask

  task automatic test_reset();
    player_inputs = '0;
    opp_x = 10'd1000;
    do_reset();
    n_tests++;
    if (player_x !== 10'd200 || player_y !== 10'd266 ||
        move_state !== S_STAND || airborne !== 1'b0 ||
        facing_left !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: x=%0d y=%0d st=%0d air=%b face=%b want 200 266 0 0 0",
               player_x, player_y, move_state, airborne, facing_left);
    end
    repeat (3) tick();
    n_tests++;
    if (player_x !== 10'd200 || player_y !== 10'd266 ||
        move_state !== S_STAND || airborne !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ticks: x=%0d y=%0d st=%0d air=%b want 200 266 0 0",
               player_x, player_y, move_state, airborne);
    end
  endtask

  task automatic test_walk();
    player_inputs = 7'b0000010;
    repeat (10) tick();
    n_tests++;
    if (player_x !== 10'd220 || move_state !== S_WALK) begin
      n_fail++;
      $display("FAIL walk_right: x=%0d st=%0d want 220 1", player_x, move_state);
    end
    repeat (6) @(negedge clk);
    n_tests++;
    if (player_x !== 10'd220) begin
      n_fail++;
      $display("FAIL hold_no_tick: x=%0d want 220", player_x);
    end
    player_inputs = 7'b0000011;
    tick();
    n_tests++;
    if (player_x !== 10'd220 || move_state !== S_STAND) begin
      n_fail++;
      $display("FAIL left_right: x=%0d st=%0d want 220 0", player_x, move_state);
    end
    player_inputs = 7'b0001010;
    tick();
    n_tests++;
    if (player_x !== 10'd220 || move_state !== S_CROUCH) begin
      n_fail++;
      $display("FAIL crouch_right: x=%0d st=%0d want 220 2", player_x, move_state);
    end
  endtask

  task automatic test_jump();
    logic [9:0] ey [25];
    ey = '{10'd254, 10'd243, 10'd233, 10'd224, 10'd216, 10'd209,
           10'd203, 10'd198, 10'd194, 10'd191, 10'd189, 10'd188,
           10'd188, 10'd189, 10'd191, 10'd194, 10'd198, 10'd203,
           10'd209, 10'd216, 10'd224, 10'd233, 10'd243, 10'd254,
           10'd266};
    player_inputs = '0;
    tick();
    player_inputs = 7'b0000100;
    tick();
    n_tests++;
    if (move_state !== S_RISE || player_y !== 10'd266 || airborne !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_start: st=%0d y=%0d air=%b want 3 266 1",
               move_state, player_y, airborne);
    end
    player_inputs = '0;
    for (int i = 0; i < 25; i++) begin
      logic [2:0] es;
      es = (i < 11) ? S_RISE : (i < 24) ? S_FALL : S_STAND;
      if (i == 24) player_inputs = 7'b0000100;
      tick();
      n_tests++;
      if (player_y !== ey[i] || move_state !== es ||
          airborne !== (i < 24) || player_x !== 10'd220) begin
        n_fail++;
        $display("FAIL jump_arc[%0d]: y=%0d st=%0d air=%b x=%0d want %0d %0d %b 220",
                 i, player_y, move_state, airborne, player_x, ey[i], es, i < 24);
      end
    end
    tick();
    n_tests++;
    if (move_state !== S_STAND || player_y !== 10'd266) begin
      n_fail++;
      $display("FAIL landing_jump_ignored: st=%0d y=%0d want 0 266",
               move_state, player_y);
    end
    player_inputs = '0;
  endtask

  task automatic test_jump_held_reset();
    player_inputs = 7'b0000100;
    do_reset();
    repeat (3) tick();
    n_tests++;
    if (move_state !== S_STAND || player_y !== 10'd266) begin
      n_fail++;
      $display("FAIL held_jump_reset: st=%0d y=%0d want 0 266", move_state, player_y);
    end
    player_inputs = '0;
    tick();
    player_inputs = 7'b0000100;
    tick();
    n_tests++;
    if (move_state !== S_RISE || airborne !== 1'b1) begin
      n_fail++;
      $display("FAIL fresh_press: st=%0d air=%b want 3 1", move_state, airborne);
    end
    tick();
    tick();
    n_tests++;
    if (player_y !== 10'd243) begin
      n_fail++;
      $display("FAIL held_in_air: y=%0d want 243", player_y);
    end
    do_reset();
    n_tests++;
    if (player_y !== 10'd266 || move_state !== S_STAND || airborne !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_jump: y=%0d st=%0d air=%b want 266 0 0",
               player_y, move_state, airborne);
    end
  endtask

  task automatic test_lr_jump();
    player_inputs = '0;
    tick();
    player_inputs = 7'b0000111;
    tick();
    n_tests++;
    if (move_state !== S_RISE || player_x !== 10'd200) begin
      n_fail++;
      $display("FAIL lr_jump: st=%0d x=%0d want 3 200", move_state, player_x);
    end
    player_inputs = '0;
  endtask

  task automatic test_screen_clamp();
    logic [9:0] ex [5];
    ex = '{10'd148, 10'd146, 10'd144, 10'd144, 10'd144};
    player_inputs = '0;
    do_reset();
    player_inputs = 7'b0000001;
    repeat (25) tick();
    n_tests++;
    if (player_x !== 10'd150) begin
      n_fail++;
      $display("FAIL walk_to_150: x=%0d want 150", player_x);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (player_x !== ex[i]) begin
        n_fail++;
        $display("FAIL left_clamp[%0d]: x=%0d want %0d", i, player_x, ex[i]);
      end
    end
    player_inputs = 7'b0000010;
    repeat (255) tick();
    n_tests++;
    if (player_x !== 10'd654) begin
      n_fail++;
      $display("FAIL walk_to_654: x=%0d want 654", player_x);
    end
    tick();
    n_tests++;
    if (player_x !== 10'd656) begin
      n_fail++;
      $display("FAIL right_656: x=%0d want 656", player_x);
    end
    tick();
    n_tests++;
    if (player_x !== 10'd656) begin
      n_fail++;
      $display("FAIL right_clamp: x=%0d want 656", player_x);
    end
  endtask

  task automatic test_opponent();
    logic [9:0] ex [4];
    ex = '{10'd202, 10'd204, 10'd204, 10'd204};
    player_inputs = '0;
    opp_x = 10'd300;
    do_reset();
    player_inputs = 7'b0000010;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (player_x !== ex[i] || facing_left !== 1'b0) begin
        n_fail++;
        $display("FAIL opp_block[%0d]: x=%0d face=%b want %0d 0",
                 i, player_x, facing_left, ex[i]);
      end
    end
    opp_x = 10'd100;
    player_inputs = '0;
    tick();
    n_tests++;
    if (facing_left !== 1'b1 || player_x !== 10'd204) begin
      n_fail++;
      $display("FAIL face_swap: face=%b x=%0d want 1 204", facing_left, player_x);
    end
    player_inputs = 7'b0000001;
    repeat (5) tick();
    n_tests++;
    if (player_x !== 10'd196) begin
      n_fail++;
      $display("FAIL opp_block_left: x=%0d want 196", player_x);
    end
    opp_x = 10'd150;
    tick();
    n_tests++;
    if (player_x !== 10'd196) begin
      n_fail++;
      $display("FAIL too_close_hold: x=%0d want 196", player_x);
    end
    player_inputs = '0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_jump();
    test_jump_held_reset();
    test_lr_jump();
    test_screen_clamp();
    test_opponent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
